// File: rtl/dac_spi_rx_model.sv
// Three-lane DAC SPI receiver: oversamples the bus on aclk, deframes 24-bit writes
// and keeps input, clearcode and output registers for each lane.
module dac_spi_rx_model #(
    parameter int SYNC_STAGES = 2,
    parameter int FRAME_W     = 24,
    parameter int DATA_W      = 20,
    parameter int CNT_W       = 16
) (
    input  logic              aclk,
    input  logic              areset,
    input  logic              spi_clk,
    input  logic              spi_syncn,
    input  logic              spi_sdox,
    input  logic              spi_sdoy,
    input  logic              spi_sdoz,
    input  logic              spi_ldacn,
    input  logic              spi_clrn,
    output logic [DATA_W-1:0] dac_x,
    output logic [DATA_W-1:0] dac_y,
    output logic [DATA_W-1:0] dac_z,
    output logic              dac_update,
    output logic              frame_valid,
    output logic [CNT_W-1:0]  frame_count,
    output logic              frame_err
);
    // state | meaning
    // IDLE  | waiting for a syncn falling edge; bit counter and shifters held clear
    // SHIFT | frame open; every spi_clk falling edge shifts one bit into each lane
    // CHECK | frame closed; validate and commit, then back to IDLE
    typedef enum logic [1:0] {IDLE, SHIFT, CHECK} state_t;

    localparam int NIN  = 7;
    localparam int BC_W = $clog2(FRAME_W + 2);
    localparam logic [BC_W-1:0] BC_FULL = BC_W'(FRAME_W);
    localparam logic [BC_W-1:0] BC_SAT  = BC_W'(FRAME_W + 1);
    // {clrn, ldacn, sdoz, sdoy, sdox, syncn, clk}; syncn/ldacn reset low so a pin
    // already low at release gives no edge, clrn resets high so no spurious clear.
    localparam logic [NIN-1:0] SYNC_RST = 7'b100_0000;

    logic [SYNC_STAGES-1:0][NIN-1:0] sync_q, sync_d;
    logic [NIN-1:0]                  in_s, prev_q, prev_d;
    state_t                          state_q, state_d;
    logic [BC_W-1:0]                 bitcnt_q, bitcnt_d;
    logic [2:0][FRAME_W-1:0]         sr_q, sr_d;
    logic [2:0][DATA_W-1:0]          inreg_q, inreg_d, clr_q, clr_d, dac_q, dac_d;
    logic                            commit_q, commit_d, upd_q, upd_d;
    logic                            fv_q, fv_d, err_q, err_d;
    logic [CNT_W-1:0]                cnt_q, cnt_d;
    logic                            commit, bad, good;
    logic                            clk_fall, sync_fall, sync_rise, ldac_fall;

    assign in_s      = sync_q[SYNC_STAGES-1];
    assign prev_d    = in_s;
    assign clk_fall  = prev_q[0] & ~in_s[0];
    assign sync_fall = prev_q[1] & ~in_s[1];
    assign sync_rise = ~prev_q[1] & in_s[1];
    assign ldac_fall = prev_q[5] & ~in_s[5];
    assign good      = (bitcnt_q == BC_FULL) && !sr_q[0][FRAME_W-1]
                       && !sr_q[1][FRAME_W-1] && !sr_q[2][FRAME_W-1];

    always_comb begin
        sync_d[0] = {spi_clrn, spi_ldacn, spi_sdoz, spi_sdoy, spi_sdox, spi_syncn, spi_clk};
        for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_d[i] = sync_q[i-1];
        end
    end

    always_comb begin
        state_d  = state_q;
        bitcnt_d = bitcnt_q;
        sr_d     = sr_q;
        commit   = 1'b0;
        bad      = 1'b0;
        case (state_q)
            IDLE: begin
                bitcnt_d = '0;
                sr_d     = '0;
                if (sync_fall) state_d = SHIFT;
            end
            SHIFT: begin
                // A closing syncn edge takes precedence over a coincident clock edge.
                if (sync_rise) begin
                    state_d = CHECK;
                end else if (clk_fall) begin
                    for (int l = 0; l < 3; l++) begin
                        sr_d[l] = {sr_q[l][FRAME_W-2:0], in_s[2+l]};
                    end
                    if (bitcnt_q != BC_SAT) bitcnt_d = bitcnt_q + BC_W'(1);
                end
            end
            CHECK: begin
                state_d = IDLE;
                commit  = good;
                bad     = !good;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        inreg_d  = inreg_q;
        clr_d    = clr_q;
        for (int l = 0; l < 3; l++) begin
            if (commit && sr_q[l][FRAME_W-2 -: 3] == 3'b001) inreg_d[l] = sr_q[l][DATA_W-1:0];
            if (commit && sr_q[l][FRAME_W-2 -: 3] == 3'b100) clr_d[l]   = sr_q[l][DATA_W-1:0];
        end
        commit_d = commit;
        fv_d     = commit;
        cnt_d    = cnt_q + CNT_W'(commit);
        err_d    = err_q | bad;
        dac_d    = dac_q;
        upd_d    = 1'b0;
        if (!in_s[6]) begin
            dac_d = clr_q;
            upd_d = 1'b1;
        end else if (ldac_fall || (!in_s[5] && commit_q)) begin
            dac_d = inreg_q;
            upd_d = 1'b1;
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            sync_q   <= {SYNC_STAGES{SYNC_RST}};
            prev_q   <= SYNC_RST;
            state_q  <= IDLE;
            bitcnt_q <= '0;
            sr_q     <= '0;
            inreg_q  <= '0;
            clr_q    <= '0;
            dac_q    <= '0;
            commit_q <= 1'b0;
            upd_q    <= 1'b0;
            fv_q     <= 1'b0;
            err_q    <= 1'b0;
            cnt_q    <= '0;
        end else begin
            sync_q   <= sync_d;
            prev_q   <= prev_d;
            state_q  <= state_d;
            bitcnt_q <= bitcnt_d;
            sr_q     <= sr_d;
            inreg_q  <= inreg_d;
            clr_q    <= clr_d;
            dac_q    <= dac_d;
            commit_q <= commit_d;
            upd_q    <= upd_d;
            fv_q     <= fv_d;
            err_q    <= err_d;
            cnt_q    <= cnt_d;
        end
    end

    assign dac_x       = dac_q[0];
    assign dac_y       = dac_q[1];
    assign dac_z       = dac_q[2];
    assign dac_update  = upd_q;
    assign frame_valid = fv_q;
    assign frame_count = cnt_q;
    assign frame_err   = err_q;

endmodule

// File: tb/tb_dac_spi_rx_model.sv
// Bench for dac_spi_rx_model: directed scenarios plus random frames checked
// against a frame-level model of the DAC registers.
module tb_dac_spi_rx_model;
    localparam int SYNC_STAGES = 2;
    localparam int CNT_W       = 4;   // narrow counter keeps the wrap scenario short

    logic              aclk = 1'b0;
    logic              areset = 1'b1;
    logic              spi_clk = 1'b0, spi_syncn = 1'b1;
    logic              spi_sdox = 1'b0, spi_sdoy = 1'b0, spi_sdoz = 1'b0;
    logic              spi_ldacn = 1'b1, spi_clrn = 1'b1;
    logic [19:0]       dac_x, dac_y, dac_z;
    logic              dac_update, frame_valid, frame_err;
    logic [CNT_W-1:0]  frame_count;

    int errors = 0;
    int checks = 0;
    int upd_cnt = 0;

    logic [19:0] m_in[3], m_clr[3], m_dac[3], dac_o[3];
    int          m_cnt;
    bit          m_err;

    dac_spi_rx_model #(.SYNC_STAGES(SYNC_STAGES), .FRAME_W(24), .DATA_W(20), .CNT_W(CNT_W)) dut (
        .aclk(aclk), .areset(areset), .spi_clk(spi_clk), .spi_syncn(spi_syncn),
        .spi_sdox(spi_sdox), .spi_sdoy(spi_sdoy), .spi_sdoz(spi_sdoz),
        .spi_ldacn(spi_ldacn), .spi_clrn(spi_clrn),
        .dac_x(dac_x), .dac_y(dac_y), .dac_z(dac_z), .dac_update(dac_update),
        .frame_valid(frame_valid), .frame_count(frame_count), .frame_err(frame_err)
    );

    always #5 aclk = ~aclk;

    always_comb begin
        dac_o[0] = dac_x;
        dac_o[1] = dac_y;
        dac_o[2] = dac_z;
    end

    always @(posedge aclk) if (dac_update) upd_cnt++;

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

    task automatic do_reset();
        areset = 1'b1;
        repeat (3) @(negedge aclk);
        areset = 1'b0;
        repeat (4) @(negedge aclk);
        for (int l = 0; l < 3; l++) begin
            m_in[l] = '0; m_clr[l] = '0; m_dac[l] = '0;
        end
        m_cnt = 0;
        m_err = 1'b0;
    endtask

    task automatic shift_bits(input int nbits, input logic [23:0] fx, fy, fz);
        logic [23:0] sx, sy, sz;
        sx = fx; sy = fy; sz = fz;
        for (int i = 0; i < nbits; i++) begin
            spi_sdox = sx[23]; spi_sdoy = sy[23]; spi_sdoz = sz[23];
            sx = sx << 1; sy = sy << 1; sz = sz << 1;
            spi_clk = 1'b1;
            repeat (2) @(negedge aclk);
            spi_clk = 1'b0;
            repeat (2) @(negedge aclk);
        end
    endtask

    task automatic send_frame(input int nbits, input logic [23:0] fx, fy, fz);
        logic [23:0] w[3];
        bit good;
        int fv_at, upd_at;
        w[0] = fx; w[1] = fy; w[2] = fz;
        good = (nbits == 24) && !fx[23] && !fy[23] && !fz[23];
        @(negedge aclk);
        spi_syncn = 1'b0;
        repeat (2) @(negedge aclk);
        shift_bits(nbits, fx, fy, fz);
        spi_syncn = 1'b1;
        fv_at = 0; upd_at = 0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge aclk);
            if (frame_valid && fv_at == 0) fv_at = k;
            if (dac_update && upd_at == 0) upd_at = k;
        end
        if (good) begin
            m_cnt++;
            for (int l = 0; l < 3; l++) begin
                if (w[l][22:20] == 3'd1) m_in[l] = w[l][19:0];
                else if (w[l][22:20] == 3'd4) m_clr[l] = w[l][19:0];
            end
            if (!spi_ldacn && spi_clrn) m_dac = m_in;
        end else begin
            m_err = 1'b1;
        end
        checks++;
        if (fv_at !== (good ? SYNC_STAGES + 2 : 0)) begin
            errors++;
            $display("FAIL frame_valid_latency: got cycle %0d, expected %0d (nbits=%0d)",
                     fv_at, good ? SYNC_STAGES + 2 : 0, nbits);
        end
        if (good && !spi_ldacn) begin
            checks++;
            if (upd_at !== fv_at + 1) begin
                errors++;
                $display("FAIL ldac_low_update_latency: got cycle %0d, expected %0d", upd_at, fv_at + 1);
            end
        end
    endtask

    task automatic ldac_pulse();
        int at, u0;
        u0 = upd_cnt; at = 0;
        @(negedge aclk);
        spi_ldacn = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            @(negedge aclk);
            if (dac_update && at == 0) at = k;
        end
        spi_ldacn = 1'b1;
        repeat (4) @(negedge aclk);
        if (spi_clrn) m_dac = m_in;
        checks++;
        if (at !== SYNC_STAGES + 1) begin
            errors++;
            $display("FAIL ldac_latency: got cycle %0d, expected %0d", at, SYNC_STAGES + 1);
        end
        checks++;
        if (upd_cnt - u0 !== 1) begin
            errors++;
            $display("FAIL ldac_update_pulses: got %0d, expected 1", upd_cnt - u0);
        end
    endtask

    task automatic test_reset();
        spi_syncn = 1'b1; spi_clk = 1'b0; spi_ldacn = 1'b1; spi_clrn = 1'b1;
        do_reset();
        for (int l = 0; l < 3; l++) begin
            checks++;
            if (dac_o[l] !== 20'h0) begin
                errors++;
                $display("FAIL reset_dac[%0d]: got %h, expected 00000", l, dac_o[l]);
            end
        end
        checks++;
        if ({dac_update, frame_valid, frame_err} !== 3'b000) begin
            errors++;
            $display("FAIL reset_flags: got upd/fv/err=%b, expected 000", {dac_update, frame_valid, frame_err});
        end
        checks++;
        if (frame_count !== '0) begin
            errors++;
            $display("FAIL reset_count: got %0d, expected 0", frame_count);
        end
    endtask

    task automatic test_basic();
        send_frame(24, 24'h1_12345, 24'h1_6789A, 24'h1_BCDEF);
        for (int l = 0; l < 3; l++) begin
            checks++;
            if (dac_o[l] !== m_dac[l]) begin
                errors++;
                $display("FAIL basic_before_ldac[%0d]: got %h, expected %h", l, dac_o[l], m_dac[l]);
            end
        end
        ldac_pulse();
        for (int l = 0; l < 3; l++) begin
            checks++;
            if (dac_o[l] !== m_dac[l]) begin
                errors++;
                $display("FAIL basic_after_ldac[%0d]: got %h, expected %h", l, dac_o[l], m_dac[l]);
            end
        end
        checks++;
        if (frame_count !== CNT_W'(m_cnt)) begin
            errors++;
            $display("FAIL basic_count: got %0d, expected %0d", frame_count, CNT_W'(m_cnt));
        end
    endtask

    task automatic test_bad_len();
        send_frame(23, 24'h1_11111, 24'h1_22222, 24'h1_33333);
        send_frame(25, 24'h1_44444, 24'h1_55555, 24'h1_66666);
        checks++;
        if (frame_err !== m_err) begin
            errors++;
            $display("FAIL badlen_err: got %b, expected %b", frame_err, m_err);
        end
        checks++;
        if (frame_count !== CNT_W'(m_cnt)) begin
            errors++;
            $display("FAIL badlen_count: got %0d, expected %0d", frame_count, CNT_W'(m_cnt));
        end
        ldac_pulse();
        for (int l = 0; l < 3; l++) begin
            checks++;
            if (dac_o[l] !== m_dac[l]) begin
                errors++;
                $display("FAIL badlen_dac[%0d]: got %h, expected %h", l, dac_o[l], m_dac[l]);
            end
        end
    endtask

    task automatic test_clear();
        int c0;
        send_frame(24, 24'h4_80000, 24'h4_80000, 24'h4_80000);
        c0 = upd_cnt;
        @(negedge aclk);
        spi_clrn = 1'b0;
        repeat (5) @(negedge aclk);
        for (int l = 0; l < 3; l++) begin
            checks++;
            if (dac_o[l] !== m_clr[l]) begin
                errors++;
                $display("FAIL clear_during[%0d]: got %h, expected %h", l, dac_o[l], m_clr[l]);
            end
        end
        repeat (5) @(negedge aclk);
        spi_clrn = 1'b1;
        m_dac = m_clr;
        repeat (6) @(negedge aclk);
        for (int l = 0; l < 3; l++) begin
            checks++;
            if (dac_o[l] !== m_dac[l]) begin
                errors++;
                $display("FAIL clear_after[%0d]: got %h, expected %h", l, dac_o[l], m_dac[l]);
            end
        end
        checks++;
        if (upd_cnt - c0 !== 10) begin
            errors++;
            $display("FAIL clear_update_pulses: got %0d, expected 10", upd_cnt - c0);
        end
        ldac_pulse();
        for (int l = 0; l < 3; l++) begin
            checks++;
            if (dac_o[l] !== m_dac[l]) begin
                errors++;
                $display("FAIL clear_then_ldac[%0d]: got %h, expected %h", l, dac_o[l], m_dac[l]);
            end
        end
    endtask

    task automatic test_ldac_low();
        @(negedge aclk);
        spi_ldacn = 1'b0;
        repeat (6) @(negedge aclk);
        m_dac = m_in;
        send_frame(24, 24'h1_00001, 24'h0_55555, 24'h7_AAAAA);
        for (int l = 0; l < 3; l++) begin
            checks++;
            if (dac_o[l] !== m_dac[l]) begin
                errors++;
                $display("FAIL ldac_low_dac[%0d]: got %h, expected %h", l, dac_o[l], m_dac[l]);
            end
        end
        spi_ldacn = 1'b1;
        repeat (4) @(negedge aclk);
    endtask

    task automatic test_reset_mid();
        @(negedge aclk);
        spi_syncn = 1'b0;
        repeat (2) @(negedge aclk);
        shift_bits(12, 24'h1_FFFFF, 24'h1_FFFFF, 24'h1_FFFFF);
        do_reset();
        repeat (4) @(negedge aclk);
        spi_syncn = 1'b1;
        repeat (6) @(negedge aclk);
        checks++;
        if (frame_err !== 1'b0 || frame_count !== '0) begin
            errors++;
            $display("FAIL midreset_state: got err=%b count=%0d, expected err=0 count=0", frame_err, frame_count);
        end
        send_frame(24, 24'h1_0ABCD, 24'h1_00042, 24'h1_FFFFF);
        ldac_pulse();
        checks++;
        if (frame_err !== m_err || frame_count !== CNT_W'(m_cnt)) begin
            errors++;
            $display("FAIL midreset_after: got err=%b count=%0d, expected err=%b count=%0d",
                     frame_err, frame_count, m_err, CNT_W'(m_cnt));
        end
        for (int l = 0; l < 3; l++) begin
            checks++;
            if (dac_o[l] !== m_dac[l]) begin
                errors++;
                $display("FAIL midreset_dac[%0d]: got %h, expected %h", l, dac_o[l], m_dac[l]);
            end
        end
    endtask

    task automatic test_random();
        logic [23:0] w[3];
        logic [2:0]  addr;
        int nb, r;
        do_reset();
        for (int n = 0; n < 16; n++) begin
            for (int l = 0; l < 3; l++) begin
                case ($urandom_range(0, 3))
                    0: addr = 3'd1;
                    1: addr = 3'd4;
                    2: addr = 3'd2;
                    default: addr = 3'($urandom_range(0, 7));
                endcase
                w[l] = {($urandom_range(0, 7) == 0), addr, 20'($urandom_range(0, 20'hFFFFF))};
            end
            r = $urandom_range(0, 9);
            nb = (r == 0) ? 23 : (r == 1) ? 25 : 24;
            send_frame(nb, w[0], w[1], w[2]);
            if ($urandom_range(0, 1) == 1) ldac_pulse();
            checks++;
            if (frame_count !== CNT_W'(m_cnt) || frame_err !== m_err) begin
                errors++;
                $display("FAIL random_status[%0d]: got count=%0d err=%b, expected count=%0d err=%b",
                         n, frame_count, frame_err, CNT_W'(m_cnt), m_err);
            end
            for (int l = 0; l < 3; l++) begin
                checks++;
                if (dac_o[l] !== m_dac[l]) begin
                    errors++;
                    $display("FAIL random_dac[%0d][%0d]: got %h, expected %h", n, l, dac_o[l], m_dac[l]);
                end
            end
        end
    endtask

    task automatic test_wrap();
        do_reset();
        for (int n = 0; n < (1 << CNT_W) + 1; n++) begin
            send_frame(24, {4'h2, 20'($urandom_range(0, 20'hFFFFF))},
                           {4'h2, 20'($urandom_range(0, 20'hFFFFF))},
                           {4'h2, 20'($urandom_range(0, 20'hFFFFF))});
        end
        ldac_pulse();
        checks++;
        if (frame_count !== CNT_W'(m_cnt) || frame_err !== m_err) begin
            errors++;
            $display("FAIL wrap_status: got count=%0d err=%b, expected count=%0d err=%b",
                     frame_count, frame_err, CNT_W'(m_cnt), m_err);
        end
        for (int l = 0; l < 3; l++) begin
            checks++;
            if (dac_o[l] !== m_dac[l]) begin
                errors++;
                $display("FAIL wrap_dac[%0d]: got %h, expected %h", l, dac_o[l], m_dac[l]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_bad_len();
        test_clear();
        test_ldac_low();
        test_reset_mid();
        test_random();
        test_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
